// File: rtl/serial_operand_feeder_if.sv
// Operand-in and bit-serial-out bundle for the serial operand feeder.
// Latency: none, wires only.
// Backpressure: carries in_valid/in_ready and ser_valid/ser_ready handshakes.
interface serial_operand_feeder_if #(
    parameter int WIDTH = 4
);
    // parallel operand channel
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    // serial bit-pair channel
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_a;
    logic             ser_b;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    // master: the feeder itself (consumes operands, sources the serial stream)
    modport master (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  ser_ready,
        output in_ready,
        output ser_valid,
        output ser_a,
        output ser_b,
        output ser_first,
        output ser_last,
        output busy
    );

    // slave: the surroundings (operand producer plus serial adder)
    modport slave (
        output in_valid,
        output in_a,
        output in_b,
        output ser_ready,
        input  in_ready,
        input  ser_valid,
        input  ser_a,
        input  ser_b,
        input  ser_first,
        input  ser_last,
        input  busy
    );
endinterface

// File: rtl/serial_operand_feeder.sv
// Serialises a parallel operand pair into LSB-first bit pairs framed by first/last.
// Latency: bit 0 valid the cycle after accept; one bit pair per transfer.
// Backpressure: ser_ready=0 freezes the stream; next pair accepted on the last transfer.
module serial_operand_feeder #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_operand_feeder_if.master bus
);

    // counter wide enough to index WIDTH-1, never narrower than one bit
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             vld_q;
    logic             first_q;
    logic             last_q;

    logic             in_ready_c;
    logic             accept;
    logic             xfer;
    logic [CW-1:0]    cnt_inc;

    // A new pair fits when idle, or when the last bit leaves on this very edge;
    // gating with rst keeps the producer from handing over a pair during reset.
    assign in_ready_c = rst & ((state == IDLE) |
                               ((state == SHIFT) & last_q & bus.ser_ready));
    assign accept     = bus.in_valid & in_ready_c;
    assign xfer       = vld_q & bus.ser_ready;
    assign cnt_inc    = cnt + CW'(1);

    // Single state machine: load on accept (wins over the final transfer so
    // back-to-back pairs run without a bubble), otherwise shift on transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            sh_a    <= '0;
            sh_b    <= '0;
            cnt     <= '0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            state   <= SHIFT;
            sh_a    <= bus.in_a;
            sh_b    <= bus.in_b;
            cnt     <= '0;
            vld_q   <= 1'b1;
            first_q <= 1'b1;
            last_q  <= (CNT_LAST == '0);
        end else if (xfer) begin
            // zeros shift in from the top, so an idle feeder presents 0 bits
            sh_a    <= sh_a >> 1;
            sh_b    <= sh_b >> 1;
            first_q <= 1'b0;
            if (last_q) begin
                state  <= IDLE;
                cnt    <= '0;
                vld_q  <= 1'b0;
                last_q <= 1'b0;
            end else begin
                cnt    <= cnt_inc;
                last_q <= (cnt_inc == CNT_LAST);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.ser_valid = vld_q;
    assign bus.busy      = vld_q;
    assign bus.ser_a     = sh_a[0];
    assign bus.ser_b     = sh_b[0];
    assign bus.ser_first = first_q;
    assign bus.ser_last  = last_q;

    // the bit counter must stay within the operand
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst)
        cnt <= CNT_LAST);

    // stream valid tracks the state encoding exactly
    a_vld_state: assert property (@(posedge clk) disable iff (!rst)
        vld_q == (state == SHIFT));

    // framing flags agree with the counter whenever a bit pair is shown
    a_frame: assert property (@(posedge clk) disable iff (!rst)
        vld_q |-> ((first_q == (cnt == '0)) && (last_q == (cnt == CNT_LAST))));

endmodule
